// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly y0 = x0 + W*x1, y1 = x0 - W*x1 with per-sample /2 scaling and saturation.
// 3-cycle latency; a single global enable (out_ready | ~out_valid) stalls all stages and drives in_ready.
module butterfly_r2_pipe #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int RH       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    x0_real,
  input  logic signed [WIDTH-1:0]    x0_img,
  input  logic signed [WIDTH-1:0]    x1_real,
  input  logic signed [WIDTH-1:0]    x1_img,
  input  logic signed [TW_WIDTH-1:0] tw_real,
  input  logic signed [TW_WIDTH-1:0] tw_img,
  input  logic                       scale,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y0_real,
  output logic [WIDTH-1:0]           y0_img,
  output logic [WIDTH-1:0]           y1_real,
  output logic [WIDTH-1:0]           y1_img,
  output logic                       out_ovf,
  input  logic                       ovf_clr,
  output logic                       ovf_sticky
);

  localparam int PW = WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam int TW = WIDTH + 2;
  localparam int AW = WIDTH + 3;

  localparam logic signed [SW-1:0] RND_C   = {{(SW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic en;

  logic                    s1_vld_q, s1_scale_q;
  logic signed [WIDTH-1:0] s1_x0r_q, s1_x0i_q;
  logic signed [PW-1:0]    s1_prr_q, s1_pii_q, s1_pri_q, s1_pir_q;
  logic signed [PW-1:0]    prr_d, pii_d, pri_d, pir_d;

  logic                    s2_vld_q, s2_scale_q;
  logic signed [WIDTH-1:0] s2_x0r_q, s2_x0i_q;
  logic signed [TW-1:0]    s2_tr_q, s2_ti_q;
  logic signed [SW-1:0]    sr_d, si_d;
  logic signed [TW-1:0]    tr_d, ti_d;

  logic signed [AW-1:0]    a0r_d, a0i_d, a1r_d, a1i_d;
  logic [WIDTH:0]          r0r_d, r0i_d, r1r_d, r1i_d;
  logic                    ovf_d;

  logic                    out_vld_q, ovf_q, sticky_q, sticky_d;
  logic [WIDTH-1:0]        y0r_q, y0i_q, y1r_q, y1i_q;

  // Returns {overflow, saturated result} for one output component.
  function automatic logic [WIDTH:0] post_proc(input logic signed [AW-1:0] v, input logic sc);
    logic signed [AW-1:0] s;
    s = sc ? ((v + AW'(RH)) >>> 1) : v;
    if (s > SAT_MAX)      post_proc = {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (s < SAT_MIN) post_proc = {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  post_proc = {1'b0, s[WIDTH-1:0]};
  endfunction

  assign en       = out_ready | ~out_vld_q;
  assign in_ready = en;

  always_comb begin
    prr_d = PW'(x1_real) * PW'(tw_real);
    pii_d = PW'(x1_img)  * PW'(tw_img);
    pri_d = PW'(x1_real) * PW'(tw_img);
    pir_d = PW'(x1_img)  * PW'(tw_real);
  end

  // One extra bit before rounding keeps (-1)*(-1) + (-1)*(-1) from wrapping.
  always_comb begin
    sr_d = SW'(s1_prr_q) - SW'(s1_pii_q) + RND_C;
    si_d = SW'(s1_pri_q) + SW'(s1_pir_q) + RND_C;
    tr_d = TW'(sr_d >>> (TW_WIDTH-1));
    ti_d = TW'(si_d >>> (TW_WIDTH-1));
  end

  always_comb begin
    a0r_d = AW'(s2_x0r_q) + AW'(s2_tr_q);
    a0i_d = AW'(s2_x0i_q) + AW'(s2_ti_q);
    a1r_d = AW'(s2_x0r_q) - AW'(s2_tr_q);
    a1i_d = AW'(s2_x0i_q) - AW'(s2_ti_q);
    r0r_d = post_proc(a0r_d, s2_scale_q);
    r0i_d = post_proc(a0i_d, s2_scale_q);
    r1r_d = post_proc(a1r_d, s2_scale_q);
    r1i_d = post_proc(a1i_d, s2_scale_q);
    ovf_d = r0r_d[WIDTH] | r0i_d[WIDTH] | r1r_d[WIDTH] | r1i_d[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_scale_q <= 1'b0;
      s1_x0r_q   <= '0;
      s1_x0i_q   <= '0;
      s1_prr_q   <= '0;
      s1_pii_q   <= '0;
      s1_pri_q   <= '0;
      s1_pir_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_scale_q <= 1'b0;
      s2_x0r_q   <= '0;
      s2_x0i_q   <= '0;
      s2_tr_q    <= '0;
      s2_ti_q    <= '0;
      out_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      y0r_q      <= '0;
      y0i_q      <= '0;
      y1r_q      <= '0;
      y1i_q      <= '0;
    end else if (en) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_scale_q <= scale;
        s1_x0r_q   <= x0_real;
        s1_x0i_q   <= x0_img;
        s1_prr_q   <= prr_d;
        s1_pii_q   <= pii_d;
        s1_pri_q   <= pri_d;
        s1_pir_q   <= pir_d;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_scale_q <= s1_scale_q;
        s2_x0r_q   <= s1_x0r_q;
        s2_x0i_q   <= s1_x0i_q;
        s2_tr_q    <= tr_d;
        s2_ti_q    <= ti_d;
      end
      // Output data only moves with a real sample so bubbles leave the last result visible.
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        ovf_q <= ovf_d;
        y0r_q <= r0r_d[WIDTH-1:0];
        y0i_q <= r0i_d[WIDTH-1:0];
        y1r_q <= r1r_d[WIDTH-1:0];
        y1i_q <= r1i_d[WIDTH-1:0];
      end
    end
  end

  assign sticky_d = (out_vld_q & ovf_q) | (sticky_q & ~ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign out_valid  = out_vld_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign y0_real    = y0r_q;
  assign y0_img     = y0i_q;
  assign y1_real    = y1r_q;
  assign y1_img     = y1i_q;

endmodule
